// File: rtl/i2s_adc_rx.sv
// I2S master receiver for the audio ADC.
// Generates BCLK/LRCLK from clk, deserializes sdata (I2S framing, one-bit
// delay, MSB first) and presents a left/right sample pair once per frame
// with a single-cycle valid strobe.
module i2s_adc_rx #(
    parameter int CLK_DIV   = 2,
    parameter int SLOT_BITS = 32,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sdata,
    output logic              bclk,
    output logic              lrclk,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    output logic              busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_LSB  = BIT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                bclk_q, bclk_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                slot_q, slot_d;
    logic [1:0]          sync_q;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   sample_l_q, sample_l_d;
    logic [DATA_W-1:0]   sample_r_q, sample_r_d;
    logic                valid_q, valid_d;

    logic                running;
    logic                tick;
    logic                fall;
    logic                last_bit;
    logic                frame_end;
    logic                in_data;
    logic [DATA_W-1:0]   word;

    // Decode the divider/bit position into the events the datapath acts on.
    always_comb begin
        running   = (state_q != S_IDLE);
        tick      = (div_cnt_q == DIV_LAST);
        fall      = tick && bclk_q;
        last_bit  = (bit_cnt_q == BIT_LAST);
        frame_end = fall && slot_q && last_bit;
        in_data   = (bit_cnt_q != '0) && (bit_cnt_q <= BIT_LSB);
        // The synchronizer output at the falling event is the bit that was on
        // the pin at the BCLK rising edge, so it completes the word directly.
        word      = {shift_q, sync_q[1]};
    end

    // Next-state: run-control FSM, clock generation and deserializer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bclk_d     = bclk_q;
        bit_cnt_d  = bit_cnt_q;
        slot_d     = slot_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        valid_d    = 1'b0;

        if (running) begin
            if (tick) begin
                div_cnt_d = '0;
                bclk_d    = ~bclk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end

            if (fall) begin
                if (last_bit) begin
                    bit_cnt_d = '0;
                    slot_d    = ~slot_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end

                if (in_data) begin
                    shift_d = word[DATA_W-2:0];
                end

                if (bit_cnt_q == BIT_LSB) begin
                    if (!slot_q) begin
                        shadow_d = word;
                    end else begin
                        sample_l_d = shadow_q;
                        sample_r_d = word;
                        valid_d    = 1'b1;
                    end
                end
            end
        end

        unique case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            // Dropping en on the very last edge of a frame needs no drain.
            S_RUN:   if (!en) state_d = frame_end ? S_IDLE : S_DRAIN;
            S_DRAIN: if (frame_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; asynchronous reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= '0;
            slot_q     <= 1'b0;
            sync_q     <= '0;
            shift_q    <= '0;
            shadow_q   <= '0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            slot_q     <= slot_d;
            sync_q     <= {sync_q[0], sdata};
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            valid_q    <= valid_d;
        end
    end

    assign bclk         = bclk_q;
    assign lrclk        = slot_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

I2S master receiver for the audio ADC. It generates BCLK and LRCLK from the system clock, deserializes the ADC's serial data, and presents one signed left/right sample pair per frame with a single-cycle valid strobe. It sits directly upstream of the IIR filter slices; `sample_l` (or a mono mix) drives their sample input, and `sample_valid` paces them.

## Interface
- `CLK_DIV`, default 2: clk cycles per BCLK half-period; must be ≥ 2.
- `SLOT_BITS`, default 32: BCLK periods per channel slot.
- `DATA_W`, default 16: sample width; must be ≤ SLOT_BITS−1.
- `clk` in 1: system clock (6 MHz HSOSC); the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: run request, level-sensitive.
- `sdata` in 1: ADC serial data, asynchronous to `clk`.
- `bclk` out 1: I2S bit clock, registered.
- `lrclk` out 1: I2S word select (0 = left, 1 = right), registered.
- `sample_l` out DATA_W: last complete left sample, two's complement.
- `sample_r` out DATA_W: last complete right sample, two's complement.
- `sample_valid` out 1: one-cycle strobe when the `sample_l`/`sample_r` pair updates.
- `busy` out 1: high while clocks are running (state RUN or DRAIN).

## Operation
- Reset values:
  - `bclk`=0, `lrclk`=0, `sample_l`=0, `sample_r`=0, `sample_valid`=0, `busy`=0.
  - All counters, the shift register and the left shadow register clear to 0.
  - State goes to IDLE.
- States:
  - IDLE: clocks held low. Goes to RUN on any clk edge where `en`=1. The first bit period starts on the next edge.
  - RUN: clocks toggle continuously. Goes to DRAIN if `en`=0 at any edge.
  - DRAIN: continues until the end of right-slot bit period SLOT_BITS−1, then goes to IDLE with `bclk`=0 and `lrclk`=0. If `en` returns to 1 during DRAIN, the block stays in DRAIN and goes IDLE→RUN afterwards.
- Counters:
  - `div_cnt` runs 0..CLK_DIV−1. `bclk` toggles on the edge where `div_cnt`=CLK_DIV−1.
  - A bit period is a low half followed by a high half of `bclk`, 2·CLK_DIV cycles in total.
  - `bit_cnt` runs 0..SLOT_BITS−1 and advances at each falling event.
  - `slot` toggles when `bit_cnt` wraps. `lrclk` = `slot`, so it changes on the same edge that drives `bclk` low.
- Input path:
  - `sdata` passes through a 2-flop synchronizer.
  - The bit is captured from the synchronizer output on the edge that ends the high phase (the falling event). That value equals the pin value at the BCLK rising edge.
- Framing (I2S, one-bit delay):
  - Bit period 0 of each slot is ignored.
  - Bit periods 1..DATA_W carry the MSB through the LSB and are shifted in MSB first.
  - Bit periods DATA_W+1..SLOT_BITS−1 are ignored.
- Outputs:
  - On the capture edge of left bit DATA_W, the completed word loads the left shadow register.
  - On the capture edge of right bit DATA_W, `sample_l` ← shadow, `sample_r` ← completed word (incoming bit included), and `sample_valid` ← 1. It returns to 0 on the next edge.
  - `sample_l`/`sample_r` hold between strobes. No arithmetic is applied; data passes through bit-exact.
- Boundaries:
  - Reset mid-frame aborts immediately with no strobe. The partial word is discarded.
  - A frame is emitted only if both of its slots were fully clocked since leaving IDLE. A partial left slot is impossible by construction, because RUN always starts at left bit 0.

## Timing
- Default frame = 2·CLK_DIV·2·SLOT_BITS = 256 clk cycles (23.4375 kHz at 6 MHz). BCLK = 1.5 MHz.
- Edge numbering: edge 1 is the first edge after leaving IDLE.
- Bit period n spans edges 4n+1..4n+4:
  - `bclk` rises at edge 4n+2.
  - `bclk` falls and capture occurs at edge 4n+4.
- First `sample_valid` is high after edge 196 (right bit period 16 of the first frame). Later strobes follow every 256 cycles.
- Latency from the BCLK rise of the right LSB to the strobe: 2 clk cycles.

## Test plan
- Reset sequence: reset low → all outputs 0. Release with `en`=1, and a bench ADC model drives sdata after each BCLK falling edge, left=0x7FFF and right=0x8000 → `sample_valid` pulses exactly once at edge 196 with `sample_l`=0x7FFF, `sample_r`=0x8000. The next pulse comes 256 cycles later.
- Framing: drive 1s in bit periods 0 and 17..31, with left=0x1234 and right=0xA5C3 → outputs are exactly 0x1234/0xA5C3. Padding bits have no effect.
- Clock shape: measure `bclk` over 64 periods → period 4 cycles with 50% duty. `lrclk` toggles only on `bclk` falling edges, every 32 BCLK periods.
- Drain: drop `en` at left bit 5 → that frame still completes and strobes, then `bclk` and `lrclk` stay low and `busy`=0. Reassert `en` → the first strobe comes 196 edges after leaving IDLE.
- Reset mid-frame: pull reset low at right bit 10 → outputs return to 0 immediately with no strobe. After release, the first strobe carries only new-frame data.
- Parameters: CLK_DIV=3, DATA_W=24, pattern 0x800001/0x7FFFFE → values are exact and the strobe comes at edge 6·(32+25)=342.
